// File: rtl/mac_array_stream.sv
// Streaming signed fixed-point multiply-accumulate array with bias, mu/var output
// mode and saturation; one result per s_last-terminated vector.
module mac_array_stream #(
    parameter int CH    = 4,
    parameter int LANES = 4,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   op_mode,
    input  logic [DW-1:0]          bias,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [CH*LANES*DW-1:0] s_act,
    input  logic [CH*LANES*DW-1:0] s_wgt,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DW-1:0]          m_data,
    output logic                   m_sat,
    output logic [15:0]            beat_cnt
);

    localparam int N  = CH * LANES;
    localparam int PW = 2 * DW;
    localparam int RW = ACC_W + 2;

    localparam logic signed [RW-1:0] HALF  = RW'(1) <<< (FRAC - 1);
    localparam logic signed [RW-1:0] MAX_V = RW'((2 ** (DW - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_V = -MAX_V - RW'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t state, state_next;
    logic [1:0] drain_cnt;

    logic signed [PW-1:0]    prod_comb [N];
    logic signed [PW-1:0]    prod_q    [N];
    logic                    prod_vld;
    logic signed [ACC_W-1:0] sum_comb;
    logic signed [ACC_W-1:0] sum_q;
    logic                    sum_vld;
    logic signed [ACC_W-1:0] acc;

    logic                    mode_q;
    logic signed [DW-1:0]    bias_q;

    logic accept;
    logic handshake;
    logic drain_done;

    logic signed [RW-1:0] acc_ext;
    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] clamped;
    logic signed [DW-1:0] res;
    logic                 res_sat;

    assign s_ready    = (state == ACCUM) && en;
    assign m_valid    = (state == OUT);
    assign accept     = s_valid && s_ready;
    assign handshake  = m_valid && m_ready;
    assign drain_done = en && (state == DRAIN) && (drain_cnt == 2'd2);

    // Result handshake is deliberately not gated by en so a stalled block can still drain.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = ACCUM;
            ACCUM:   if (accept && s_last) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = OUT;
            OUT:     if (m_ready) state_next = ACCUM;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= IDLE;
            drain_cnt <= 2'd0;
        end else begin
            state <= state_next;
            if (en && state == DRAIN)
                drain_cnt <= (drain_cnt == 2'd2) ? 2'd0 : drain_cnt + 2'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            prod_comb[k] = {{DW{s_act[k*DW+DW-1]}}, s_act[k*DW +: DW]}
                         * {{DW{s_wgt[k*DW+DW-1]}}, s_wgt[k*DW +: DW]};
        end
    end

    always_comb begin
        sum_comb = '0;
        for (int k = 0; k < N; k++)
            sum_comb = sum_comb + {{(ACC_W-PW){prod_q[k][PW-1]}}, prod_q[k]};
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prod_vld <= 1'b0;
            sum_vld  <= 1'b0;
            sum_q    <= '0;
            for (int k = 0; k < N; k++)
                prod_q[k] <= '0;
        end else if (en) begin
            prod_vld <= accept;
            if (accept) begin
                for (int k = 0; k < N; k++)
                    prod_q[k] <= prod_comb[k];
            end
            sum_vld <= prod_vld;
            sum_q   <= sum_comb;
        end
    end

    // The pipeline is empty by the time of the handshake, so clearing here loses nothing.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (handshake) begin
            acc <= '0;
        end else if (en && sum_vld) begin
            acc <= acc + sum_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            beat_cnt <= 16'd0;
            mode_q   <= 1'b0;
            bias_q   <= '0;
        end else if (handshake) begin
            beat_cnt <= 16'd0;
        end else if (accept) begin
            if (beat_cnt != 16'hFFFF)
                beat_cnt <= beat_cnt + 16'd1;
            if (beat_cnt == 16'd0) begin
                mode_q <= op_mode;
                bias_q <= bias;
            end
        end
    end

    // Round half up, add bias, clamp negatives in var mode, then saturate to DW.
    always_comb begin
        acc_ext = {{(RW-ACC_W){acc[ACC_W-1]}}, acc};
        rounded = (acc_ext + HALF) >>> FRAC;
        biased  = rounded + {{(RW-DW){bias_q[DW-1]}}, bias_q};
        clamped = (mode_q && biased < 0) ? '0 : biased;
        res_sat = 1'b0;
        res     = clamped[DW-1:0];
        if (clamped > MAX_V) begin
            res     = MAX_V[DW-1:0];
            res_sat = 1'b1;
        end else if (clamped < MIN_V) begin
            res     = MIN_V[DW-1:0];
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            m_data <= '0;
            m_sat  <= 1'b0;
        end else if (drain_done) begin
            m_data <= res;
            m_sat  <= res_sat;
        end
    end

endmodule

// File: tb/tb_mac_array_stream.sv
// Directed self-checking bench for mac_array_stream: latency, arithmetic,
// saturation, back-pressure, clr/rst abort and enable freeze.
module tb_mac_array_stream;

    localparam int CH    = 4;
    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int N     = CH * LANES;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            clr;
    logic            op_mode;
    logic [DW-1:0]   bias;
    logic            s_valid;
    logic            s_ready;
    logic [N*DW-1:0] s_act;
    logic [N*DW-1:0] s_wgt;
    logic            s_last;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic            m_sat;
    logic [15:0]     beat_cnt;

    int compare_count  = 0;
    int mismatch_count = 0;

    mac_array_stream #(.CH(CH), .LANES(LANES), .DW(DW), .FRAC(8), .ACC_W(40)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .op_mode(op_mode), .bias(bias),
        .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_wgt(s_wgt),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sat(m_sat), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and returns 1ns after the edge that accepted it.
    task automatic applyStimulus(input logic [DW-1:0] act, input logic [DW-1:0] wgt,
                                 input logic last);
        logic ok;
        ok      = 1'b0;
        s_act   = {N{act}};
        s_wgt   = {N{wgt}};
        s_last  = last;
        s_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (s_ready) ok = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) checkOutput("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitResult();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_valid) ok = 1'b1;
            else tick();
        end
        if (!ok) checkOutput("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume(input string tag, input logic exp_ready);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checkOutput({tag, "_mvalid_drop"}, m_valid, 0);
        checkOutput({tag, "_sready_after"}, s_ready, exp_ready);
    endtask

    task automatic runVector(input string tag, input int n, input logic [DW-1:0] act,
                             input logic [DW-1:0] wgt, input logic mode,
                             input logic [DW-1:0] b, input logic [DW-1:0] exp_data,
                             input logic exp_sat);
        op_mode = mode;
        bias    = b;
        for (int i = 0; i < n; i++)
            applyStimulus(act, wgt, i == n - 1);
        checkOutput({tag, "_sready_drain"}, s_ready, 0);
        waitResult();
        checkOutput({tag, "_data"}, m_data, exp_data);
        checkOutput({tag, "_sat"}, m_sat, exp_sat);
        checkOutput({tag, "_beats"}, beat_cnt, n);
        checkOutput({tag, "_sready_out"}, s_ready, 0);
        consume(tag, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; op_mode = 1'b0; bias = '0;
        s_valid = 1'b0; s_last = 1'b0; s_act = '0; s_wgt = '0; m_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_sready", s_ready, 0);
        checkOutput("rst_mvalid", m_valid, 0);
        checkOutput("rst_mdata", m_data, 0);
        checkOutput("rst_msat", m_sat, 0);
        checkOutput("rst_beats", beat_cnt, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_to_accum", s_ready, 1);

        // Single beat, 16 x (1.0*1.0) = 16.0, with cycle-exact latency.
        applyStimulus(16'h0100, 16'h0100, 1'b1);
        checkOutput("lat_t0_mvalid", m_valid, 0);
        checkOutput("lat_t0_beats", beat_cnt, 1);
        tick();
        checkOutput("lat_t1_mvalid", m_valid, 0);
        tick();
        checkOutput("lat_t2_mvalid", m_valid, 0);
        checkOutput("lat_t2_sready", s_ready, 0);
        tick();
        checkOutput("lat_t3_mvalid", m_valid, 1);
        checkOutput("lat_t3_data", m_data, 16'h1000);
        checkOutput("lat_t3_sat", m_sat, 0);
        consume("lat", 1'b1);

        runVector("three_beat", 3, 16'h0100, 16'h0100, 1'b0, 16'h0080, 16'h3080, 1'b0);
        runVector("neg_mu", 1, 16'h0100, 16'hFF00, 1'b0, 16'h0000, 16'hF000, 1'b0);
        runVector("neg_var", 1, 16'h0100, 16'hFF00, 1'b1, 16'h0000, 16'h0000, 1'b0);
        runVector("sat_pos", 1, 16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 16'h7FFF, 1'b1);
        runVector("sat_neg", 1, 16'h7FFF, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1);

        // Back-pressure: result and input stall hold while m_ready is low.
        op_mode = 1'b0;
        bias    = 16'h0080;
        applyStimulus(16'h0100, 16'h0100, 1'b1);
        bias    = 16'h0000;
        waitResult();
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_data", m_data, 16'h1080);
            checkOutput("hold_mvalid", m_valid, 1);
            checkOutput("hold_sready", s_ready, 0);
            tick();
        end
        consume("hold", 1'b1);

        // Abort mid-vector with clr, then with rst.
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(16'h0100, 16'h0100, 1'b0);
            applyStimulus(16'h0100, 16'h0100, 1'b0);
            if (pass == 0) clr = 1'b1;
            else rst = 1'b1;
            tick();
            clr = 1'b0;
            rst = 1'b0;
            checkOutput("abort_sready", s_ready, 0);
            checkOutput("abort_beats", beat_cnt, 0);
            checkOutput("abort_mvalid", m_valid, 0);
            runVector(pass == 0 ? "after_clr" : "after_rst", 1, 16'h0100, 16'h0100,
                      1'b0, 16'h0000, 16'h1000, 1'b0);
        end

        // en=0 freezes the pipeline mid-flight.
        applyStimulus(16'h0100, 16'h0100, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("freeze_mvalid", m_valid, 0);
        checkOutput("freeze_sready", s_ready, 0);
        en = 1'b1;
        waitResult();
        checkOutput("freeze_data", m_data, 16'h1000);

        // A result handshake still completes while en=0.
        en = 1'b0;
        consume("en_off_hs", 1'b0);
        checkOutput("en_off_beats", beat_cnt, 0);
        en = 1'b1;
        #1;
        checkOutput("en_on_sready", s_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/mac_array_stream.md
Name: mac_array_stream

Overview:
- Parametrised successor to the fixed 4×64-bit MAC array in the encoder datapath.
- Streams CH channels × LANES signed fixed-point activation/weight pairs per beat and accumulates products over a variable-length vector terminated by s_last.
- Adds bias, applies the mu/var output mode, and returns one saturated result per vector over valid/ready handshakes.
- Feeds the mu and var heads of the VAE encoder.

Parameters:
- CH, 4, number of input channels.
- LANES, 4, elements per channel per beat.
- DW, 16, element, bias and result width (signed).
- FRAC, 8, fractional bits (default format Q8.8).
- ACC_W, 40, accumulator width (signed).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global enable; 0 freezes all state.
- clr  in  1  synchronous abort; clears accumulator and pipeline, returns to IDLE.
- op_mode  in  1  0 = mu (signed result), 1 = var (negative results clamped to 0); sampled on the first accepted beat of a vector.
- bias  in  DW  Q-format bias; sampled with op_mode.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accept.
- s_act  in  CH*LANES*DW  activations; element k at [k*DW +: DW].
- s_wgt  in  CH*LANES*DW  weights, same packing.
- s_last  in  1  final beat of the vector.
- m_valid  out  1  result valid.
- m_ready  in  1  result accept.
- m_data  out  DW  result.
- m_sat  out  1  result was saturated.
- beat_cnt  out  16  beats accepted in the current vector.

Behaviour:
- Reset and clr values: s_ready=0, m_valid=0, m_data=0, m_sat=0, beat_cnt=0, accumulator=0, state=IDLE. rst takes priority over clr; clr takes priority over all other activity.
- States:
  - IDLE→ACCUM on the next cycle when not in reset.
  - ACCUM: s_ready=en. A beat is accepted when s_valid&&s_ready. On s_last acceptance → DRAIN.
  - DRAIN: s_ready=0. Lasts 3 cycles.
  - OUT: m_valid=1. On m_valid&&m_ready → ACCUM, accumulator and beat_cnt cleared the same edge.
- Pipeline:
  - P1 registers all CH*LANES full-precision products (2*DW signed).
  - P2 registers the adder-tree sum, sign-extended to ACC_W.
  - P3 adds the sum into the accumulator.
- Latency: s_last accepted at edge t → m_valid=1 after edge t+3. Beats accepted back-to-back at 1 beat/cycle.
- Result computation:
  - r = (acc + 2^(FRAC-1)) >>> FRAC (round half up).
  - r += sign-extended bias.
  - If op_mode=1 and r<0, r=0.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1]; m_sat=1 iff clipping occurred.
  - Accumulator wraps silently at ACC_W; no detection is required.
- Hold rules:
  - m_data and m_sat stay stable while m_valid&&!m_ready.
  - s_ready stays 0 until the result is consumed; no overlap between vectors.
- en=0: every register holds and s_ready=0; m_valid holds its value. A handshake with m_valid=1 and m_ready=1 still completes while en=0.
- beat_cnt increments per accepted beat and saturates at 0xFFFF.
- A single beat with s_last=1 is a valid vector of length 1.

Test Plan:
- Defaults, mode 0, bias 0x0000; one beat, all act=wgt=0x0100, s_last=1 → m_data=0x1000 (16.0), m_sat=0, m_valid asserted 3 cycles after acceptance edge.
- 3 back-to-back beats as above, s_last on beat 3, bias 0x0080 → m_data=0x3080, beat_cnt=3, s_ready low from beat 3 until handshake.
- act=0x0100, wgt=0xFF00, one beat: mode 0 → m_data=0xF000; mode 1 → m_data=0x0000, m_sat=0.
- act=wgt=0x7FFF, one beat, mode 0 → m_data=0x7FFF, m_sat=1; act=0x7FFF, wgt=0x8000 → m_data=0x8000, m_sat=1.
- m_ready held 0 for 5 cycles after m_valid → m_data stable, s_ready=0; then m_ready=1 for one cycle → m_valid drops, s_ready=1 next cycle.
- Assert clr after beat 2 of a 3-beat vector, then send a fresh 1-beat 1.0×1.0 vector → m_data=0x1000. Repeat with rst instead of clr → same result.
